// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divide sequencer for the EX stage.
// Accepts one DIV/DIVU operand pair, iterates 32 cycles, then holds
// {remainder, quotient} on result_o with ready_o high until start_i drops.
// Optional feature macro: DIV_EARLY_OUT_EN (skip iteration when |dividend| < |divisor|).
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [1:0] StFree   = 2'd0;
    localparam logic [1:0] StByZero = 2'd1;
    localparam logic [1:0] StOn     = 2'd2;
    localparam logic [1:0] StEnd    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [31:0] dq_q, dq_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] rem_q, rem_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic        signed_q, signed_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] mag_a, mag_b;
    logic [32:0] partial, diff;
    logic        q_bit;
    logic [31:0] rem_next, quot_next, rem_fix, quot_fix;
    logic        early_out;

    // Operand magnitudes as seen at the accept cycle.
    assign mag_a = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign mag_b = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

    // One restoring iteration: shift in next dividend bit, trial-subtract divisor.
    assign partial   = {rem_q, dq_q[31]};
    assign diff      = partial - {1'b0, dvsr_q};
    assign q_bit     = ~diff[32];
    assign rem_next  = q_bit ? diff[31:0] : partial[31:0];
    assign quot_next = {dq_q[30:0], q_bit};

    // Sign correction; 0x80000000 / -1 naturally wraps back to 0x80000000.
    assign quot_fix = (signed_q && (neg_a_q ^ neg_b_q)) ? -quot_next : quot_next;
    assign rem_fix  = (signed_q && neg_a_q) ? -rem_next : rem_next;

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (opdata2_i != 32'd0) && (mag_a < mag_b);
`else
    assign early_out = 1'b0;
`endif

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dq_d     = dq_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        signed_d = signed_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            StFree: begin
                if (annul_i) begin
                    state_d = StFree;
                end else if (start_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = StByZero;
                    end else if (early_out) begin
                        // Quotient 0, remainder is the untouched dividend.
                        state_d  = StEnd;
                        ready_d  = 1'b1;
                        result_d = {opdata1_i, 32'd0};
                    end else begin
                        state_d  = StOn;
                        cnt_d    = 5'd0;
                        dq_d     = mag_a;
                        dvsr_d   = mag_b;
                        rem_d    = 32'd0;
                        neg_a_d  = signed_div_i & opdata1_i[31];
                        neg_b_d  = signed_div_i & opdata2_i[31];
                        signed_d = signed_div_i;
                    end
                end
            end
            StByZero: begin
                state_d  = StEnd;
                ready_d  = 1'b1;
                result_d = 64'd0;
            end
            StOn: begin
                if (annul_i) begin
                    state_d = StFree;
                    cnt_d   = 5'd0;
                end else begin
                    dq_d  = quot_next;
                    rem_d = rem_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = StEnd;
                        ready_d  = 1'b1;
                        result_d = {rem_fix, quot_fix};
                    end
                end
            end
            StEnd: begin
                // annul_i is ignored here: the result is already committed.
                if (!start_i) begin
                    state_d  = StFree;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end
            default: state_d = StFree;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StFree;
            cnt_q    <= 5'd0;
            dq_q     <= 32'd0;
            dvsr_q   <= 32'd0;
            rem_q    <= 32'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            signed_q <= 1'b0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dq_q     <= dq_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            signed_q <= signed_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and randomized checks of div_ctrl against an
// arithmetic reference model (64-bit integer divide) and expected latencies.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: truncating integer division in 64-bit arithmetic, {rem, quot}.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Expected cycles from the accept cycle to ready_o first high.
    function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb;
        if (b == 32'd0) return 2;
        ma = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        mb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`else
        if (ma < mb) return 33;
`endif
        return 33;
    endfunction

    // Issue a divide, scramble operands after accept, check latency, result, hold and release.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [63:0] exp_res;
        int          exp_lat;
        int          lat;
        exp_res      = ref_div(sgn, a, b);
        exp_lat      = ref_lat(sgn, a, b);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        lat          = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (lat == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            if (ready_o === 1'b1) break;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result_o, exp_res);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold ready"}, 64'(ready_o), 64'd1);
            check({tag, " hold result"}, result_o, exp_res);
        end
        start_i = 1'b0;
        tick();
        check({tag, " drop ready"}, 64'(ready_o), 64'd0);
        check({tag, " drop result"}, result_o, 64'd0);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a, b;
        int          mode;

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        tick();
        tick();
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        rst = 1'b0;
        tick();
        check("idle ready", 64'(ready_o), 64'd0);

        // Directed cases from the test plan.
        do_div("udiv 100/7", 1'b0, 32'd100, 32'd7, 1);
        check("udiv 100/7 const", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        do_div("sdiv -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 1);
        check("sdiv -7/2 const", ref_div(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        do_div("sdiv min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1);
        do_div("div by zero", 1'b1, 32'd1234, 32'd0, 1);
        do_div("hold 5", 1'b0, 32'd1000, 32'd33, 5);
        do_div("early 5/9", 1'b0, 32'd5, 32'd9, 1);
        do_div("early -5/9", 1'b1, 32'hFFFFFFFB, 32'd9, 1);
        // Back-to-back: new start in the FREE cycle right after the drop.
        do_div("b2b", 1'b0, 32'hFFFFFFFF, 32'd16, 0);

        // Annul at ON iteration 10.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        annul_i = 1'b1;
        tick();
        check("annul ready", 64'(ready_o), 64'd0);
        check("annul result", result_o, 64'd0);
        tick();
        check("annul held free", 64'(ready_o), 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < 35; i++) tick();
        check("annul no late ready", 64'(ready_o), 64'd0);
        do_div("after annul 9/3", 1'b0, 32'd9, 32'd3, 1);

        // Synchronous reset in the middle of ON.
        signed_div_i = 1'b1;
        opdata1_i    = 32'h12345678;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        check("mid rst ready", 64'(ready_o), 64'd0);
        check("mid rst result", result_o, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < 35; i++) tick();
        check("post rst idle", 64'(ready_o), 64'd0);
        do_div("post rst 9/3", 1'b0, 32'd9, 32'd3, 1);

        // Randomized operands across several classes.
        for (int n = 0; n < 24; n++) begin
            sgn  = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            a    = $urandom;
            b    = $urandom;
            case (mode)
                1: b = 32'($urandom_range(0, 5));
                2: a = 32'($urandom_range(0, 50));
                3: b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h80000000;
                default: ;
            endcase
            do_div("random", sgn, a, b, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
